// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: line address, line data, byte select and
// the line responder state encoding.
package lc3b_types;

  localparam int unsigned LC3B_LINE_ADDR_W = 12;
  localparam int unsigned LC3B_LINE_W      = 128;
  localparam int unsigned LC3B_LINE_SEL_W  = LC3B_LINE_W / 8;

  typedef logic [LC3B_LINE_ADDR_W-1:0] lc3b_line_addr;
  typedef logic [LC3B_LINE_W-1:0]      lc3b_line;
  typedef logic [LC3B_LINE_SEL_W-1:0]  lc3b_line_sel;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    WB,
    FILL
  } wbr_state_t;

endpackage

// File: rtl/line_byte_merge.sv
// Combinational byte merge: each byte of new_data replaces the matching byte
// of old_line where its select bit is set.
module line_byte_merge #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned SEL_W  = LINE_W / 8
) (
  input  logic [LINE_W-1:0] old_line,
  input  logic [LINE_W-1:0] new_data,
  input  logic [SEL_W-1:0]  sel,
  output logic [LINE_W-1:0] merged
);

  always_comb begin
    merged = old_line;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      if (sel[i]) begin
        merged[8*i +: 8] = new_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/wb_line_responder.sv
// Wishbone line responder backed by a single-entry write-back line buffer.
// Define WB_LINE_RESPONDER_HITMISS_EN to add registered hit_pulse/miss_pulse outputs.
module wb_line_responder
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned SEL_W  = LINE_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [LINE_W-1:0] wb_dat_m,
  output logic [LINE_W-1:0] wb_dat_s,
  output logic              wb_ack,
  output logic              wb_rty,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef WB_LINE_RESPONDER_HITMISS_EN
  ,
  output logic              hit_pulse,
  output logic              miss_pulse
`endif
);

  wbr_state_t        state_q, state_d;
  logic              valid_q, valid_d;
  logic              dirty_q, dirty_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              ack_q, ack_d;
  logic [LINE_W-1:0] dat_s_q, dat_s_d;
  logic              pread_q, pread_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [LINE_W-1:0] pwdata_q, pwdata_d;

  logic              request;
  logic              hit;
  logic [LINE_W-1:0] merged;

  assign request = wb_cyc & wb_stb;
  assign hit     = valid_q & (tag_q == wb_adr);

  line_byte_merge #(
    .LINE_W (LINE_W),
    .SEL_W  (SEL_W)
  ) u_merge (
    .old_line (line_q),
    .new_data (wb_dat_m),
    .sel      (wb_sel),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      dirty_q  <= 1'b0;
      tag_q    <= '0;
      line_q   <= '0;
      ack_q    <= 1'b0;
      dat_s_q  <= '0;
      pread_q  <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      tag_q    <= tag_d;
      line_q   <= line_d;
      ack_q    <= ack_d;
      dat_s_q  <= dat_s_d;
      pread_q  <= pread_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    tag_d    = tag_q;
    line_d   = line_q;
    ack_d    = 1'b0;
    dat_s_d  = dat_s_q;
    pread_d  = pread_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;

    case (state_q)
      IDLE: begin
        if (request) begin
          if (hit) begin
            state_d = RESP;
            ack_d   = 1'b1;
            if (wb_we) begin
              line_d  = merged;
              dirty_d = 1'b1;
              dat_s_d = merged;
            end else begin
              dat_s_d = line_q;
            end
          end else if (valid_q && dirty_q) begin
            state_d  = WB;
            pwrite_d = 1'b1;
            paddr_d  = tag_q;
            pwdata_d = line_q;
          end else begin
            state_d = FILL;
            pread_d = 1'b1;
            paddr_d = wb_adr;
          end
        end
      end
      RESP: state_d = IDLE;
      WB: begin
        // Line stays valid but clean; the fill that follows replaces it.
        if (pmem_resp) begin
          pwrite_d = 1'b0;
          dirty_d  = 1'b0;
          pread_d  = 1'b1;
          paddr_d  = wb_adr;
          state_d  = FILL;
        end
      end
      FILL: begin
        // Return to IDLE so the still-held request is re-sampled as a hit.
        if (pmem_resp) begin
          pread_d = 1'b0;
          line_d  = pmem_rdata;
          tag_d   = paddr_q;
          valid_d = 1'b1;
          dirty_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_ack     = ack_q;
  assign wb_dat_s   = dat_s_q;
  assign wb_rty     = 1'b0;
  assign pmem_read  = pread_q;
  assign pmem_write = pwrite_q;
  assign pmem_addr  = paddr_q;
  assign pmem_wdata = pwdata_q;

`ifdef WB_LINE_RESPONDER_HITMISS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      hit_pulse  <= (state_q == IDLE) & request & hit;
      miss_pulse <= (state_q == IDLE) & request & ~hit;
    end
  end
`endif

endmodule
